flash_cmd_ctrl: RTL
===================

// Module: flash_cmd_ctrl
// PURPOSE
//  Synchronous host-side command sequencer upstream of the flash core. Turns single-beat
//  host read/write requests into the core's 3-cycle unlock/opcode bus protocol
//  (5555/AA, AAAA/55, 5555/10|20), then one data cycle. Generates nEN/nRE/nWE/Addr and
//  drives/samples the bidirectional 8-bit IO bus with fixed, parameterised phase timing.
// PARAMETERS
//  T_SU   1  clocks Addr/IO set-up before strobe falls (>=1)
//  T_WP   2  clocks nWE low per write cycle (>=2; IO drive starts in 2nd WP clock)
//  T_HLD  1  clocks strobes high after each bus cycle, Addr held (>=1)
//  T_ACC  3  clocks nRE low before IO sampled; T_ACC*Tclk must exceed core access time
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  nReset     in   1   asynchronous, active-low reset
//  req_valid  in   1   host request present
//  req_ready  out  1   controller idle, request accepted on valid&&ready
//  req_wr     in   1   1=write, 0=read
//  req_addr   in   16  flash byte address
//  req_wdata  in   8   write data
//  rsp_valid  out  1   one-clock pulse, transaction complete
//  rsp_rdata  out  8   read data (valid with rsp_valid on reads; holds last value)
//  rsp_err    out  1   write-verify mismatch, valid with rsp_valid
//  f_nReset   out  1   core reset
//  f_nEN      out  1   core enable, low for whole transaction
//  f_nRE      out  1   core read strobe
//  f_nWE      out  1   core write strobe
//  f_Addr     out  16  core address
//  f_IO       inout 8  core data bus, tri-stated unless driving a write cycle
// BEHAVIOUR
//  Reset (async): req_ready=0 until first clk after release; rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, f_nEN=f_nRE=f_nWE=1, f_Addr=0, f_IO=Z. f_nReset low asynchronously,
//   released one clk after nReset deasserts. Reset mid-transaction: bus returns to
//   idle immediately, request dropped, no rsp_valid.
//  Handshake: req_ready=1 only in IDLE; request fields captured on acceptance; req_valid
//   while busy is ignored (ready=0). Request accepted in IDLE cycle is the only one.
//  Top FSM: IDLE -> UNLK1 -> UNLK2 -> OPC -> (WDAT | RDAT) -> RESP -> IDLE.
//   UNLK1 = wr cycle 5555/AA, UNLK2 = AAAA/55, OPC = 5555/20 (wr) or 5555/10 (rd),
//   WDAT = wr cycle req_addr/req_wdata, RDAT = rd cycle req_addr. RESP pulses rsp_valid.
//  Write bus cycle: SU (T_SU, strobes high, Addr set, IO=Z) -> WP (nWE=0; IO=Z in
//   1st WP clk to avoid contention while core drops its output, driven from 2nd) ->
//   HLD (nWE=1, IO still driven, Addr held) -> IO=Z. Length T_SU+T_WP+T_HLD.
//  Read bus cycle: SU (IO=Z) -> ACC (nRE=0, T_ACC clks, IO sampled on last ACC edge
//   into rsp_rdata) -> HLD (nRE=1). Length T_SU+T_ACC+T_HLD. nRE and nWE never both low.
//  f_nEN low from first SU of UNLK1 through HLD of last cycle; high in IDLE/RESP.
//  Latency (defaults, accept edge = 0): write rsp_valid at clk 17, read at clk 18.
//  Any 16-bit address legal incl. 0x0000/0xFFFF and 0x5555/0xAAAA; data 0xAA etc. as data.
// CONFIGURATION
//  FLASH_WR_VERIFY_EN defined: after WDAT, run full read transaction (UNLK1,UNLK2,
//   OPC=10, RDAT) on req_addr; rsp_err=1 if read byte != req_wdata; rsp_rdata = read
//   byte. Write latency 34 clks (defaults). Undefined: no verify, rsp_err tied 0.
// STRUCTURE
//  Package flash_ctrl_pkg: top FSM state encoding, unlock constants (ADDR_U1=16'h5555,
//   ADDR_U2=16'hAAAA, DAT_U1=8'hAA, DAT_U2=8'h55, OP_RD=8'h10, OP_WR=8'h20), default timings.
//  Sub-module flash_bus_cycle: one read or write bus cycle (start, is_rd, addr, wdata ->
//   done pulse, rdata, strobes, io_oe); top FSM sequences it, owns f_nEN/f_nReset.
// TESTING (bench instantiates flash core as bus model, clk 10 ns)
//  Write 0x1234<=0x5A -> bus shows 5555/AA, AAAA/55, 5555/20, 1234/5A; rsp_valid clk 17.
//  Read 0x1234 after above -> rsp_rdata=0x5A, rsp_valid clk 18; untouched 0x0102 -> 0x02.
//  Back-to-back req_valid held high -> second accepted only after RESP; no IO contention
//   (monitor: core and controller never drive f_IO in same clk).
//  nReset pulse during OPC of a write -> strobes/IO idle at once, no rsp_valid, mem unchanged.
//  FLASH_WR_VERIFY_EN: write 0xFFFF<=0xAA -> rsp_err=0, rsp_rdata=0xAA, rsp_valid clk 34;
//   forced-corrupt bus model -> rsp_err=1.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared constants for the flash command controller: unlock/opcode values,
// default bus-phase timings and the FSM encodings used by the top and the bus-cycle engine.
package flash_ctrl_pkg;

  localparam int T_SU_DEF  = 1;
  localparam int T_WP_DEF  = 2;
  localparam int T_HLD_DEF = 1;
  localparam int T_ACC_DEF = 3;

  localparam logic [15:0] ADDR_U1 = 16'h5555;
  localparam logic [15:0] ADDR_U2 = 16'hAAAA;
  localparam logic [7:0]  DAT_U1  = 8'hAA;
  localparam logic [7:0]  DAT_U2  = 8'h55;
  localparam logic [7:0]  OP_RD   = 8'h10;
  localparam logic [7:0]  OP_WR   = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE, ST_UNLK1, ST_UNLK2, ST_OPC, ST_WDAT, ST_RDAT, ST_RESP
  } top_st_e;

  // PH_STB is the strobe-low phase: write pulse (WP) or read access (ACC).
  typedef enum logic [1:0] {
    PH_IDLE, PH_SU, PH_STB, PH_HLD
  } bus_ph_e;

endpackage

// File: rtl/flash_bus_cycle.sv
// One flash bus cycle (read or write): set-up, strobe and hold phases with fixed clock counts.
// A start coinciding with done chains the next cycle with no idle clock in between.
module flash_bus_cycle
  import flash_ctrl_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_WP  = T_WP_DEF,
  parameter int T_HLD = T_HLD_DEF,
  parameter int T_ACC = T_ACC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_rd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  io_in,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        nre,
  output logic        nwe,
  output logic [15:0] f_addr,
  output logic        io_oe,
  output logic [7:0]  io_out
);

  bus_ph_e     r_ph;
  logic [7:0]  r_cnt;
  logic        r_rd;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  w_len;
  logic        w_last;

  always_comb begin
    w_len = 8'(T_SU);
    unique case (r_ph)
      PH_STB:  w_len = r_rd ? 8'(T_ACC) : 8'(T_WP);
      PH_HLD:  w_len = 8'(T_HLD);
      default: w_len = 8'(T_SU);
    endcase
  end

  assign w_last = (r_cnt == w_len - 8'd1);
  assign done   = (r_ph == PH_HLD) && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph    <= PH_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      // Read data is taken on the edge that ends the access window.
      if (r_ph == PH_STB && r_rd && w_last) r_rdata <= io_in;
      if (start) begin
        r_ph    <= PH_SU;
        r_cnt   <= '0;
        r_rd    <= is_rd;
        r_addr  <= addr;
        r_wdata <= wdata;
      end else if (r_ph != PH_IDLE) begin
        if (w_last) begin
          r_cnt <= '0;
          unique case (r_ph)
            PH_SU:   r_ph <= PH_STB;
            PH_STB:  r_ph <= PH_HLD;
            default: r_ph <= PH_IDLE;
          endcase
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign nre    = !(r_ph == PH_STB && r_rd);
  assign nwe    = !(r_ph == PH_STB && !r_rd);
  // First write-pulse clock stays tri-stated so the core can release the bus.
  assign io_oe  = !r_rd && ((r_ph == PH_STB && r_cnt != 8'd0) || r_ph == PH_HLD);
  assign io_out = r_wdata;
  assign f_addr = r_addr;
  assign rdata  = r_rdata;

endmodule

// File: rtl/flash_cmd_ctrl.sv
// Host-side flash command sequencer: unlock, opcode, then one data bus cycle per request.
// Define FLASH_WR_VERIFY_EN to read back every write and flag a mismatch on rsp_err.
module flash_cmd_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_WP  = T_WP_DEF,
  parameter int T_HLD = T_HLD_DEF,
  parameter int T_ACC = T_ACC_DEF
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        f_nReset,
  output logic        f_nEN,
  output logic        f_nRE,
  output logic        f_nWE,
  output logic [15:0] f_Addr,
  inout  wire  [7:0]  f_IO
);

  top_st_e     r_st, w_nxt;
  logic        r_nrst;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;

  logic        w_accept, w_rd_path;
  logic        w_start, w_is_rd, w_done;
  logic [15:0] w_cyc_addr;
  logic [7:0]  w_cyc_data;
  logic [7:0]  w_bus_rdata;
  logic        w_oe;
  logic [7:0]  w_io_out;

  assign req_ready = r_nrst && (r_st == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

`ifdef FLASH_WR_VERIFY_EN
  logic r_vfy;
  logic r_err;
  // A verify pass reuses the read path on the same address.
  assign w_rd_path = !r_wr || r_vfy;
  assign rsp_err   = (r_st == ST_RESP) && r_err;
`else
  assign w_rd_path = !r_wr;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    w_nxt      = r_st;
    w_start    = 1'b0;
    w_is_rd    = 1'b0;
    w_cyc_addr = ADDR_U1;
    w_cyc_data = DAT_U1;
    unique case (r_st)
      ST_IDLE:  if (w_accept) begin
        w_nxt   = ST_UNLK1;
        w_start = 1'b1;
      end
      ST_UNLK1: if (w_done) begin
        w_nxt      = ST_UNLK2;
        w_start    = 1'b1;
        w_cyc_addr = ADDR_U2;
        w_cyc_data = DAT_U2;
      end
      ST_UNLK2: if (w_done) begin
        w_nxt      = ST_OPC;
        w_start    = 1'b1;
        w_cyc_data = w_rd_path ? OP_RD : OP_WR;
      end
      ST_OPC:   if (w_done) begin
        w_nxt      = w_rd_path ? ST_RDAT : ST_WDAT;
        w_start    = 1'b1;
        w_is_rd    = w_rd_path;
        w_cyc_addr = r_addr;
        w_cyc_data = r_wdata;
      end
      ST_WDAT:  if (w_done) begin
`ifdef FLASH_WR_VERIFY_EN
        w_nxt   = ST_UNLK1;
        w_start = 1'b1;
`else
        w_nxt   = ST_RESP;
`endif
      end
      ST_RDAT:  if (w_done) w_nxt = ST_RESP;
      ST_RESP:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_st    <= ST_IDLE;
      r_nrst  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_st   <= w_nxt;
      r_nrst <= 1'b1;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_st == ST_RDAT && w_done) r_rdata <= w_bus_rdata;
    end
  end

`ifdef FLASH_WR_VERIFY_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_vfy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_vfy <= 1'b0;
      else if (r_st == ST_WDAT && w_done) r_vfy <= 1'b1;
      if (r_st == ST_RDAT && w_done) r_err <= r_wr && (w_bus_rdata != r_wdata);
    end
  end
`endif

  flash_bus_cycle #(
    .T_SU (T_SU),
    .T_WP (T_WP),
    .T_HLD(T_HLD),
    .T_ACC(T_ACC)
  ) u_bus (
    .clk   (clk),
    .rst_n (nReset),
    .start (w_start),
    .is_rd (w_is_rd),
    .addr  (w_cyc_addr),
    .wdata (w_cyc_data),
    .io_in (f_IO),
    .done  (w_done),
    .rdata (w_bus_rdata),
    .nre   (f_nRE),
    .nwe   (f_nWE),
    .f_addr(f_Addr),
    .io_oe (w_oe),
    .io_out(w_io_out)
  );

  assign rsp_valid = (r_st == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign f_nReset  = r_nrst;
  assign f_nEN     = (r_st == ST_IDLE) || (r_st == ST_RESP);
  assign f_IO      = w_oe ? w_io_out : 8'bz;

endmodule
